// File: rtl/int_div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Holds the controller state encoding and the RISC-V special-case result values.
package int_div_pkg;

   localparam int XLEN_C = 32;
   localparam int DIV_STEPS = 32;
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
   localparam logic [31:0] INT_MIN = 32'h80000000;
   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NEG_A,
      ST_NEG_B,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } div_state_e;

endpackage

// File: rtl/int_add_sub.sv
// Shared W-bit adder/subtractor: i_mode=1 gives i_a - i_b, i_mode=0 gives i_a + i_b.
// Subtraction reuses the same carry chain via invert-and-carry-in.
module int_add_sub
   import int_div_pkg::*;
#(
   parameter int W = XLEN_C
) (
   input  logic         i_mode,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_result
);

   assign o_result = i_a + (i_b ^ {W{i_mode}}) + {{(W-1){1'b0}}, i_mode};

endmodule

// File: rtl/int_div_seq.sv
// Iterative DIV/DIVU/REM/REMU controller: sign-fix, 32 restoring steps, sign correction,
// all through one shared adder. Optional flush port enabled by `define INT_DIV_FLUSH_EN.
module int_div_seq
   import int_div_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit SPECIAL_FAST = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic            i_signed,
   input  logic            i_rem,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
`ifdef INT_DIV_FLUSH_EN
   input  logic            i_flush,
`endif
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result
);

   div_state_e      state_reg;
   logic [XLEN-1:0] dvd_reg;
   logic [XLEN-1:0] dvs_reg;
   logic [XLEN-1:0] rem_reg;
   logic [XLEN-1:0] spec_res_reg;
   logic [XLEN-1:0] result_reg;
   logic [4:0]      cnt_reg;
   logic            signed_reg;
   logic            rem_sel_reg;
   logic            neg_q_reg;
   logic            neg_r_reg;
   logic            special_reg;
   logic            ready_reg;
   logic            valid_reg;

   logic            flush;
   logic            add_mode;
   logic [XLEN-1:0] add_a;
   logic [XLEN-1:0] add_b;
   logic [XLEN-1:0] add_res;
   logic [XLEN-1:0] sh;
   logic            borrow;

`ifdef INT_DIV_FLUSH_EN
   assign flush = i_flush;
`else
   assign flush = 1'b0;
`endif

   assign o_ready  = ready_reg;
   assign o_valid  = valid_reg;
   assign o_result = result_reg;

   // Bit 32 of the shifted partial remainder is rem_reg[31]; it forces "no borrow".
   assign sh     = {rem_reg[XLEN-2:0], dvd_reg[XLEN-1]};
   assign borrow = ~rem_reg[XLEN-1]
                 & ((~sh[XLEN-1] & dvs_reg[XLEN-1])
                  | (~(sh[XLEN-1] ^ dvs_reg[XLEN-1]) & add_res[XLEN-1]));

   always_comb begin
      add_mode = 1'b0;
      add_a    = '0;
      add_b    = '0;
      case (state_reg)
         ST_NEG_A: begin
            add_b    = dvd_reg;
            add_mode = signed_reg & dvd_reg[XLEN-1];
         end
         ST_NEG_B: begin
            add_b    = dvs_reg;
            add_mode = signed_reg & dvs_reg[XLEN-1];
         end
         ST_CALC: begin
            add_a    = sh;
            add_b    = dvs_reg;
            add_mode = 1'b1;
         end
         ST_FIX: begin
            add_b    = rem_sel_reg ? rem_reg : dvd_reg;
            add_mode = rem_sel_reg ? neg_r_reg : neg_q_reg;
         end
         default: ;
      endcase
   end

   int_add_sub #(.W(XLEN)) u_add_sub (
      .i_mode   (add_mode),
      .i_a      (add_a),
      .i_b      (add_b),
      .o_result (add_res)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg    <= ST_IDLE;
         dvd_reg      <= '0;
         dvs_reg      <= '0;
         rem_reg      <= '0;
         spec_res_reg <= '0;
         result_reg   <= '0;
         cnt_reg      <= '0;
         signed_reg   <= 1'b0;
         rem_sel_reg  <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         special_reg  <= 1'b0;
         ready_reg    <= 1'b1;
         valid_reg    <= 1'b0;
      end else if (flush && state_reg != ST_IDLE) begin
         state_reg <= ST_IDLE;
         ready_reg <= 1'b1;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_valid && ready_reg && !flush) begin
                  dvd_reg     <= i_a;
                  dvs_reg     <= i_b;
                  signed_reg  <= i_signed;
                  rem_sel_reg <= i_rem;
                  // A zero divisor must return all-ones even for a negative dividend.
                  neg_q_reg   <= i_signed & (i_a[XLEN-1] ^ i_b[XLEN-1]) & (|i_b);
                  neg_r_reg   <= i_signed & i_a[XLEN-1];
                  special_reg <= (i_b == '0)
                               | (i_signed & (i_a == INT_MIN) & (i_b == DIV_BY_ZERO_Q));
                  if (i_b == '0)
                     spec_res_reg <= i_rem ? i_a : DIV_BY_ZERO_Q;
                  else
                     spec_res_reg <= i_rem ? '0 : INT_MIN;
                  ready_reg <= 1'b0;
                  state_reg <= ST_NEG_A;
               end
            end
            ST_NEG_A: begin
               // Fast special cases exit here so o_valid rises one edge after acceptance.
               if (SPECIAL_FAST && special_reg) begin
                  result_reg <= spec_res_reg;
                  valid_reg  <= 1'b1;
                  state_reg  <= ST_DONE;
               end else begin
                  dvd_reg   <= add_res;
                  state_reg <= ST_NEG_B;
               end
            end
            ST_NEG_B: begin
               dvs_reg   <= add_res;
               rem_reg   <= '0;
               cnt_reg   <= '0;
               state_reg <= ST_CALC;
            end
            ST_CALC: begin
               rem_reg <= borrow ? sh : add_res;
               dvd_reg <= {dvd_reg[XLEN-2:0], ~borrow};
               cnt_reg <= cnt_reg + 5'd1;
               if (cnt_reg == LAST_STEP)
                  state_reg <= ST_FIX;
            end
            ST_FIX: begin
               result_reg <= add_res;
               valid_reg  <= 1'b1;
               state_reg  <= ST_DONE;
            end
            ST_DONE: begin
               if (i_ready) begin
                  valid_reg <= 1'b0;
                  ready_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_div_seq.sv
// Self-checking bench: a fast-special and a full-sequence divider run the same requests
// and are compared against a plain-arithmetic RISC-V division model.
`timescale 1ns/1ps
module tb_int_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_signed;
   logic        req_rem;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        res_ready;
   logic        flush;
   logic        f_ready, f_valid;
   logic [31:0] f_result;
   logic        s_ready, s_valid;
   logic [31:0] s_result;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   int_div_seq #(.XLEN(32), .SPECIAL_FAST(1'b1)) dut_fast (
      .i_clk(clk), .i_rst(rst), .i_valid(req_valid), .o_ready(f_ready),
      .i_signed(req_signed), .i_rem(req_rem), .i_a(req_a), .i_b(req_b),
`ifdef INT_DIV_FLUSH_EN
      .i_flush(flush),
`endif
      .o_valid(f_valid), .i_ready(res_ready), .o_result(f_result)
   );

   int_div_seq #(.XLEN(32), .SPECIAL_FAST(1'b0)) dut_slow (
      .i_clk(clk), .i_rst(rst), .i_valid(req_valid), .o_ready(s_ready),
      .i_signed(req_signed), .i_rem(req_rem), .i_a(req_a), .i_b(req_b),
`ifdef INT_DIV_FLUSH_EN
      .i_flush(flush),
`endif
      .o_valid(s_valid), .i_ready(res_ready), .o_result(s_result)
   );

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic r);
      longint sa, sb;
      if (b == 32'd0) return r ? a : 32'hFFFFFFFF;
      if (s) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) return r ? 32'd0 : 32'h80000000;
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return r ? 32'(sa % sb) : 32'(sa / sb);
      end
      return r ? a % b : a / b;
   endfunction

   function automatic int fast_latency(input logic [31:0] a, input logic [31:0] b,
                                       input logic s);
      if (b == 32'd0 || (s && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
      return 35;
   endfunction

   // Issues one request to both dividers, records each result and latency, then handshakes.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic r, output logic [31:0] res_f, output logic [31:0] res_s,
                        output int lat_f, output int lat_s);
      lat_f = -1;
      lat_s = -1;
      res_f = '0;
      res_s = '0;
      for (int i = 0; i < 50 && !(f_ready && s_ready); i++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b1; req_a = a; req_b = b; req_signed = s; req_rem = r;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_signed = $urandom; req_rem = $urandom;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk);
         #1;
         if (f_valid && lat_f < 0) begin lat_f = cyc; res_f = f_result; end
         if (s_valid && lat_s < 0) begin lat_s = cyc; res_s = s_result; end
         if (lat_f >= 0 && lat_s >= 0) break;
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      $display("op a=%08h b=%08h signed=%0d rem=%0d -> fast=%08h (lat %0d) slow=%08h (lat %0d)",
               a, b, s, r, res_f, lat_f, res_s, lat_s);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 6;
      if (f_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_fast got %0b want 1", f_ready); end
      if (f_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_fast got %0b want 0", f_valid); end
      if (f_result !== 32'd0) begin failures++; $display("FAIL reset_result_fast got %08h want 0", f_result); end
      if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_slow got %0b want 1", s_ready); end
      if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_slow got %0b want 0", s_valid); end
      if (s_result !== 32'd0) begin failures++; $display("FAIL reset_result_slow got %08h want 0", s_result); end
      rst = 1'b0;
   endtask

   task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic r);
      logic [31:0] rf, rs, exp;
      int lf, ls, exp_lf;
      do_op(a, b, s, r, rf, rs, lf, ls);
      exp = model(a, b, s, r);
      exp_lf = fast_latency(a, b, s);
      checks += 4;
      if (rf !== exp) begin failures++; $display("FAIL %s result_fast got %08h want %08h", name, rf, exp); end
      if (rs !== exp) begin failures++; $display("FAIL %s result_slow got %08h want %08h", name, rs, exp); end
      if (lf != exp_lf) begin failures++; $display("FAIL %s latency_fast got %0d want %0d", name, lf, exp_lf); end
      if (ls != 35) begin failures++; $display("FAIL %s latency_slow got %0d want 35", name, ls); end
   endtask

   task automatic test_directed();
      check_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
      check_op("urem_100_7", 32'd100, 32'd7, 1'b0, 1'b1);
      check_op("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
      check_op("srem_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1);
      check_op("udiv_33bit", 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0);
      check_op("urem_33bit", 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b1);
      check_op("div_by_zero_q", 32'd5, 32'd0, 1'b0, 1'b0);
      check_op("div_by_zero_r", 32'd5, 32'd0, 1'b0, 1'b1);
      check_op("sdiv_neg_by_zero", 32'hFFFFFFF9, 32'd0, 1'b1, 1'b0);
      check_op("srem_neg_by_zero", 32'hFFFFFFF9, 32'd0, 1'b1, 1'b1);
      check_op("overflow_q", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      check_op("overflow_r", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
      check_op("udiv_intmin_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int n = 0; n < 24; n++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            4: a = 32'($urandom_range(0, 300));
            default: ;
         endcase
         check_op("random", a, b, 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_backpressure();
      int waited = 0;
      @(negedge clk);
      req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7; req_signed = 1'b0; req_rem = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      while (!f_valid && waited < 60) begin @(posedge clk); #1; waited++; end
      checks++;
      if (!f_valid) begin failures++; $display("FAIL bp_timeout got valid=0 want 1"); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks += 3;
         if (f_result !== 32'd14) begin failures++; $display("FAIL bp_hold_result got %08h want 0000000e", f_result); end
         if (f_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got %0b want 0", f_ready); end
         if (s_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid_slow got %0b want 1", s_valid); end
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      checks += 2;
      if (f_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got %0b want 1", f_ready); end
      if (f_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got %0b want 0", f_valid); end
      $display("op backpressure 100/7 held 5 cycles, released");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7; req_signed = 1'b0; req_rem = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks += 4;
      if (f_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready_fast got %0b want 1", f_ready); end
      if (f_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid_fast got %0b want 0", f_valid); end
      if (s_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready_slow got %0b want 1", s_ready); end
      if (s_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid_slow got %0b want 0", s_valid); end
      @(negedge clk);
      rst = 1'b0;
      $display("op reset during CALC step 10");
      check_op("after_reset_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
   endtask

`ifdef INT_DIV_FLUSH_EN
   task automatic test_flush();
      @(negedge clk);
      req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7; req_signed = 1'b0; req_rem = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      checks += 2;
      if (f_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got %0b want 1", f_ready); end
      if (f_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %0b want 0", f_valid); end
      @(posedge clk);
      #1;
      checks++;
      if (f_ready !== 1'b1) begin failures++; $display("FAIL flush_blocks_accept got ready=%0b want 1", f_ready); end
      @(negedge clk);
      flush = 1'b0;
      req_valid = 1'b0;
      $display("op flush mid-divide and in idle");
      check_op("after_flush_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_signed = 1'b0; req_rem = 1'b0;
      req_a = '0; req_b = '0; res_ready = 1'b0; flush = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
`ifdef INT_DIV_FLUSH_EN
      test_flush();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
